mct_kernel_ctrl: RTL and testbench

//  Parametrised kernel-control sequencer for multi-channel MCT kernels: turns the SDx ap_start level into per-channel

---
 rtl/mct_ctrl_pkg.sv | 31 +++
 rtl/mct_done_tracker.sv | 58 +++++
 rtl/mct_kernel_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_mct_kernel_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mct_ctrl_pkg.sv
// ============================================================================
// Module      : mct_ctrl_pkg
// Description : Shared types and constants for the MCT kernel-control
//               sequencer: FSM state encoding, status bit positions and the
//               default cache-line size.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mct_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Bit positions inside the status output
    localparam int STATUS_OVF  = 0;
    localparam int STATUS_SPUR = 1;
    localparam int STATUS_TMO  = 2;
    localparam int STATUS_BUSY = 3;

    // 64-byte cache lines
    localparam int CL_BYTES_LOG2_DEF = 6;

endpackage

`default_nettype wire

// File: rtl/mct_done_tracker.sv
// ============================================================================
// Module      : mct_done_tracker
// Description : Sticky per-channel completion mask. Cleared at job start,
//               preset with zero-length channels at launch, then collects
//               done pulses while running. Reports "all channels complete"
//               including the pulses of the current cycle, and flags pulses
//               that arrive on an already-complete channel or outside RUN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mct_done_tracker #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         preset_en,
    input  logic [N-1:0] preset_mask,
    input  logic         run_en,
    input  logic [N-1:0] done_in,
    output logic         all_done,
    output logic         spurious
);

    logic [N-1:0] mask_q;
    logic [N-1:0] mask_d;

    // Next mask: clear wins, then launch preset, then sticky accumulation
    always_comb begin
        mask_d = mask_q;
        if (clr) begin
            mask_d = '0;
        end else if (preset_en) begin
            mask_d = preset_mask;
        end else if (run_en) begin
            mask_d = mask_q | done_in;
        end
    end

    // Mask register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    // The completing pulse itself counts toward "all done"
    assign all_done = &(mask_q | done_in);

    // Outside RUN every pulse is unexpected; inside RUN only repeats are
    assign spurious = run_en ? |(done_in & mask_q) : |done_in;

endmodule

`default_nettype wire

// File: rtl/mct_kernel_ctrl.sv
// ============================================================================
// Module      : mct_kernel_ctrl
// Description : Kernel-control sequencer. Converts the ap_start level into
//               per-channel launch pulses with latched byte counts, waits
//               for every channel to report completion (or the watchdog),
//               then issues ap_done. Tracks run cycles and error status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mct_kernel_ctrl
    import mct_ctrl_pkg::*;
#(
    parameter int NUM_RD_CH     = 2,
    parameter int NUM_WR_CH     = 1,
    parameter int XFER_W        = 32,
    parameter int CL_BYTES_LOG2 = CL_BYTES_LOG2_DEF,
    parameter int CYC_W         = 48,
    parameter int TIMEOUT_CYC   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ap_start,
    output logic                          ap_idle,
    output logic                          ap_done,
    input  logic [NUM_RD_CH*XFER_W-1:0]   rdNumCLs,
    input  logic [NUM_WR_CH*XFER_W-1:0]   wrNumCLs,
    output logic [NUM_RD_CH-1:0]          rd_start,
    output logic [NUM_WR_CH-1:0]          wr_start,
    output logic [NUM_RD_CH*XFER_W-1:0]   rd_xfer_bytes,
    output logic [NUM_WR_CH*XFER_W-1:0]   wr_xfer_bytes,
    input  logic [NUM_RD_CH-1:0]          rd_done,
    input  logic [NUM_WR_CH-1:0]          wr_done,
    output logic [CYC_W-1:0]              run_cycles,
    output logic [3:0]                    status
);

    // Shifted count is widened so bits pushed out of XFER_W stay visible
    localparam int WIDE_W = XFER_W + CL_BYTES_LOG2 + 1;
    // Last run_cycles value before the watchdog fires (all ones when disabled)
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(TIMEOUT_CYC - 1);

    state_t                        state_q;
    state_t                        state_d;
    logic                          ap_start_q;
    logic [NUM_RD_CH*XFER_W-1:0]   rd_bytes_q;
    logic [NUM_RD_CH*XFER_W-1:0]   rd_bytes_d;
    logic [NUM_WR_CH*XFER_W-1:0]   wr_bytes_q;
    logic [NUM_WR_CH*XFER_W-1:0]   wr_bytes_d;
    logic [CYC_W-1:0]              run_cycles_q;
    logic [CYC_W-1:0]              run_cycles_d;
    logic [2:0]                    status_q;
    logic [2:0]                    status_d;
    logic [NUM_RD_CH-1:0]          rd_start_q;
    logic [NUM_RD_CH-1:0]          rd_start_d;
    logic [NUM_WR_CH-1:0]          wr_start_q;
    logic [NUM_WR_CH-1:0]          wr_start_d;

    logic                          start_pulse;
    logic                          clr_masks;
    logic [NUM_RD_CH*XFER_W-1:0]   rd_bytes_calc;
    logic [NUM_WR_CH*XFER_W-1:0]   wr_bytes_calc;
    logic [NUM_RD_CH-1:0]          rd_ovf;
    logic [NUM_WR_CH-1:0]          wr_ovf;
    logic [NUM_RD_CH-1:0]          rd_nz;
    logic [NUM_WR_CH-1:0]          wr_nz;
    logic                          rd_all_done;
    logic                          wr_all_done;
    logic                          rd_spur;
    logic                          wr_spur;

    assign start_pulse = ap_start & ~ap_start_q;

    // Per read channel: cache lines to bytes with saturation on overflow
    generate
        for (genvar i = 0; i < NUM_RD_CH; i++) begin : g_rd_ch
            logic [WIDE_W-1:0] wide;
            assign wide = {{(CL_BYTES_LOG2 + 1){1'b0}}, rdNumCLs[i*XFER_W +: XFER_W]} << CL_BYTES_LOG2;
            assign rd_ovf[i] = |wide[WIDE_W-1:XFER_W];
            assign rd_bytes_calc[i*XFER_W +: XFER_W] = rd_ovf[i] ? {XFER_W{1'b1}} : wide[XFER_W-1:0];
            assign rd_nz[i] = |rd_bytes_q[i*XFER_W +: XFER_W];
        end
    endgenerate

    // Per write channel: same conversion as the read side
    generate
        for (genvar i = 0; i < NUM_WR_CH; i++) begin : g_wr_ch
            logic [WIDE_W-1:0] wide;
            assign wide = {{(CL_BYTES_LOG2 + 1){1'b0}}, wrNumCLs[i*XFER_W +: XFER_W]} << CL_BYTES_LOG2;
            assign wr_ovf[i] = |wide[WIDE_W-1:XFER_W];
            assign wr_bytes_calc[i*XFER_W +: XFER_W] = wr_ovf[i] ? {XFER_W{1'b1}} : wide[XFER_W-1:0];
            assign wr_nz[i] = |wr_bytes_q[i*XFER_W +: XFER_W];
        end
    endgenerate

    mct_done_tracker #(
        .N (NUM_RD_CH)
    ) u_rd_tracker (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr_masks),
        .preset_en   (state_q == LAUNCH),
        .preset_mask (~rd_nz),
        .run_en      (state_q == RUN),
        .done_in     (rd_done),
        .all_done    (rd_all_done),
        .spurious    (rd_spur)
    );

    mct_done_tracker #(
        .N (NUM_WR_CH)
    ) u_wr_tracker (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr_masks),
        .preset_en   (state_q == LAUNCH),
        .preset_mask (~wr_nz),
        .run_en      (state_q == RUN),
        .done_in     (wr_done),
        .all_done    (wr_all_done),
        .spurious    (wr_spur)
    );

    // Next-state and datapath updates for the sequencer
    always_comb begin
        state_d      = state_q;
        rd_bytes_d   = rd_bytes_q;
        wr_bytes_d   = wr_bytes_q;
        run_cycles_d = run_cycles_q;
        status_d     = status_q;
        rd_start_d   = '0;
        wr_start_d   = '0;
        clr_masks    = 1'b0;

        if (rd_spur || wr_spur) begin
            status_d[STATUS_SPUR] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    rd_bytes_d             = rd_bytes_calc;
                    wr_bytes_d             = wr_bytes_calc;
                    status_d               = '0;
                    status_d[STATUS_OVF]   = |{rd_ovf, wr_ovf};
                    run_cycles_d           = '0;
                    clr_masks              = 1'b1;
                    state_d                = LAUNCH;
                end
            end
            LAUNCH: begin
                rd_start_d = rd_nz;
                wr_start_d = wr_nz;
                state_d    = RUN;
            end
            RUN: begin
                if (run_cycles_q != {CYC_W{1'b1}}) begin
                    run_cycles_d = run_cycles_q + CYC_W'(1);
                end
                if (rd_all_done && wr_all_done) begin
                    state_d = DONE;
                end else if ((TIMEOUT_CYC != 0) && (run_cycles_q == TIMEOUT_LAST)) begin
                    status_d[STATUS_TMO] = 1'b1;
                    state_d              = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ap_start_q   <= 1'b0;
            rd_bytes_q   <= '0;
            wr_bytes_q   <= '0;
            run_cycles_q <= '0;
            status_q     <= '0;
            rd_start_q   <= '0;
            wr_start_q   <= '0;
        end else begin
            state_q      <= state_d;
            ap_start_q   <= ap_start;
            rd_bytes_q   <= rd_bytes_d;
            wr_bytes_q   <= wr_bytes_d;
            run_cycles_q <= run_cycles_d;
            status_q     <= status_d;
            rd_start_q   <= rd_start_d;
            wr_start_q   <= wr_start_d;
        end
    end

    assign ap_idle                         = (state_q == IDLE);
    assign ap_done                         = (state_q == DONE);
    assign rd_start                        = rd_start_q;
    assign wr_start                        = wr_start_q;
    assign rd_xfer_bytes                   = rd_bytes_q;
    assign wr_xfer_bytes                   = wr_bytes_q;
    assign run_cycles                      = run_cycles_q;
    assign status[STATUS_BUSY]             = (state_q != IDLE);
    assign status[STATUS_TMO:STATUS_OVF]   = status_q;

endmodule

`default_nettype wire

// File: tb/tb_mct_kernel_ctrl.sv
// ============================================================================
// Module      : tb_mct_kernel_ctrl
// Description : Self-checking bench for mct_kernel_ctrl (watchdog = 16).
//               Directed job table, held-start / reset / idle-pulse
//               sequences, then randomized jobs against a job-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mct_kernel_ctrl;

    localparam int TMO = 16;

    logic         clk;
    logic         rst;
    logic         ap_start;
    logic         ap_idle;
    logic         ap_done;
    logic [63:0]  rdNumCLs;
    logic [31:0]  wrNumCLs;
    logic [1:0]   rd_start;
    logic [0:0]   wr_start;
    logic [63:0]  rd_xfer_bytes;
    logic [31:0]  wr_xfer_bytes;
    logic [1:0]   rd_done;
    logic [0:0]   wr_done;
    logic [47:0]  run_cycles;
    logic [3:0]   status;

    int n_checks = 0;
    int n_errors = 0;

    mct_kernel_ctrl #(
        .NUM_RD_CH     (2),
        .NUM_WR_CH     (1),
        .XFER_W        (32),
        .CL_BYTES_LOG2 (6),
        .CYC_W         (48),
        .TIMEOUT_CYC   (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ap_start      (ap_start),
        .ap_idle       (ap_idle),
        .ap_done       (ap_done),
        .rdNumCLs      (rdNumCLs),
        .wrNumCLs      (wrNumCLs),
        .rd_start      (rd_start),
        .wr_start      (wr_start),
        .rd_xfer_bytes (rd_xfer_bytes),
        .wr_xfer_bytes (wr_xfer_bytes),
        .rd_done       (rd_done),
        .wr_done       (wr_done),
        .run_cycles    (run_cycles),
        .status        (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Job: cache-line counts and RUN-cycle index of each done pulse (0 = none)
    typedef struct {
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] w0;
        int          d0;
        int          d1;
        int          dw;
        int          dup;   // extra rd_done[0] pulse
    } job_t;

    typedef struct {
        logic [31:0] b0;
        logic [31:0] b1;
        logic [31:0] bw;
        logic [1:0]  rs;
        logic        ws;
        int          run;
        logic [3:0]  st;
    } exp_t;

    typedef struct {
        job_t j;
        exp_t e;
    } vec_t;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Job-level reference: completion is when the last nonzero channel has
    // seen its first pulse, capped by the watchdog; repeats that land before
    // completion, or pulses on zero-length channels, are spurious.
    function automatic exp_t model(input job_t j);
        exp_t            e;
        longint unsigned cls [3];
        longint unsigned by  [3];
        int              p   [3][2];
        bit              nz  [3];
        bit              ovf, tmo, spur, any_nz;
        int              tdone, fin, cnt, first;
        cls = '{longint'(j.r0), longint'(j.r1), longint'(j.w0)};
        p   = '{'{j.d0, j.dup}, '{j.d1, 0}, '{j.dw, 0}};
        ovf = 0;
        for (int c = 0; c < 3; c++) begin
            by[c] = cls[c] * 64;
            if (by[c] > 64'hFFFF_FFFF) begin
                by[c] = 64'hFFFF_FFFF;
                ovf   = 1;
            end
            nz[c] = (by[c] != 0);
        end
        tdone  = 0;
        any_nz = 0;
        for (int c = 0; c < 3; c++) begin
            if (nz[c]) begin
                any_nz = 1;
                first  = 1000;
                for (int q = 0; q < 2; q++)
                    if (p[c][q] > 0 && p[c][q] < first) first = p[c][q];
                if (first > tdone) tdone = first;
            end
        end
        if (!any_nz) tdone = 1;
        if (tdone <= TMO) begin fin = tdone; tmo = 0; end
        else              begin fin = TMO;   tmo = 1; end
        spur = 0;
        for (int c = 0; c < 3; c++) begin
            cnt = 0;
            for (int q = 0; q < 2; q++)
                if (p[c][q] > 0 && p[c][q] <= fin) cnt++;
            if (cnt >= 2 || (!nz[c] && cnt >= 1)) spur = 1;
        end
        e.b0  = by[0][31:0];
        e.b1  = by[1][31:0];
        e.bw  = by[2][31:0];
        e.rs  = {nz[1], nz[0]};
        e.ws  = nz[2];
        e.run = fin;
        e.st  = {1'b1, tmo, spur, ovf};
        return e;
    endfunction

    // Run one job from an idle DUT; sampling and driving on negedges
    task automatic run_job(input job_t j, input exp_t e, input bit keep);
        int  fin;
        bit  seen;
        ap_start = 1'b0;
        rd_done  = '0;
        wr_done  = '0;
        @(negedge clk);
        rdNumCLs = {j.r1, j.r0};
        wrNumCLs = j.w0;
        ap_start = 1'b1;
        @(negedge clk);
        chk("launch_idle", ap_idle, 0);
        chk("launch_no_start", {rd_start, wr_start}, 0);
        @(negedge clk);
        chk("rd_start", rd_start, e.rs);
        chk("wr_start", wr_start, e.ws);
        chk("rd_bytes0", rd_xfer_bytes[31:0], e.b0);
        chk("rd_bytes1", rd_xfer_bytes[63:32], e.b1);
        chk("wr_bytes", wr_xfer_bytes, e.bw);
        chk("run_status", status, {2'b10, 1'b0, e.st[0]});
        seen = 0;
        fin  = -1;
        for (int k = 1; k <= 40 && !seen; k++) begin
            rd_done = '0;
            wr_done = '0;
            if (ap_done) begin
                seen = 1;
                fin  = k - 1;
            end else begin
                rd_done[0] = (j.d0 == k) || (j.dup == k);
                rd_done[1] = (j.d1 == k);
                wr_done[0] = (j.dw == k);
                @(negedge clk);
            end
        end
        rd_done = '0;
        wr_done = '0;
        chk("done_cycle", fin, e.run);
        chk("run_cycles", run_cycles, e.run);
        chk("done_status", status, e.st);
        @(negedge clk);
        chk("idle_after", {ap_idle, ap_done}, 2'b10);
        chk("idle_status", status, {1'b0, e.st[2:0]});
        if (!keep) ap_start = 1'b0;
    endtask

    vec_t tbl [8];

    initial begin
        rst      = 1'b1;
        ap_start = 1'b0;
        rdNumCLs = '0;
        wrNumCLs = '0;
        rd_done  = '0;
        wr_done  = '0;

        tbl[0] = '{'{32'd2, 32'd4, 32'd1, 3, 7, 5, 0},
                   '{32'd128, 32'd256, 32'd64, 2'b11, 1'b1, 7, 4'b1000}};
        tbl[1] = '{'{32'd0, 32'd3, 32'd2, 0, 4, 2, 0},
                   '{32'd0, 32'd192, 32'd128, 2'b10, 1'b1, 4, 4'b1000}};
        tbl[2] = '{'{32'h0400_0001, 32'd1, 32'd1, 2, 2, 3, 0},
                   '{32'hFFFF_FFFF, 32'd64, 32'd64, 2'b11, 1'b1, 3, 4'b1001}};
        tbl[3] = '{'{32'd1, 32'd1, 32'd1, 2, 3, 0, 5},
                   '{32'd64, 32'd64, 32'd64, 2'b11, 1'b1, 16, 4'b1110}};
        tbl[4] = '{'{32'd0, 32'd0, 32'd0, 0, 0, 0, 0},
                   '{32'd0, 32'd0, 32'd0, 2'b00, 1'b0, 1, 4'b1000}};
        tbl[5] = '{'{32'd0, 32'd1, 32'd1, 1, 2, 2, 0},
                   '{32'd0, 32'd64, 32'd64, 2'b10, 1'b1, 2, 4'b1010}};
        tbl[6] = '{'{32'd1, 32'd1, 32'd1, 6, 3, 4, 2},
                   '{32'd64, 32'd64, 32'd64, 2'b11, 1'b1, 4, 4'b1000}};
        tbl[7] = '{'{32'h03FF_FFFF, 32'd0, 32'h0400_0000, 1, 0, 15, 0},
                   '{32'hFFFF_FFC0, 32'd0, 32'hFFFF_FFFF, 2'b01, 1'b1, 15, 4'b1001}};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_idle_done", {ap_idle, ap_done}, 2'b10);
        chk("rst_starts", {rd_start, wr_start}, 0);
        chk("rst_bytes", {rd_xfer_bytes, wr_xfer_bytes}, 0);
        chk("rst_status_cycles", {status, run_cycles}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed jobs
        for (int i = 0; i < 8; i++) run_job(tbl[i].j, tbl[i].e, 1'b0);

        // Start level held across DONE must not retrigger
        run_job(tbl[0].j, tbl[0].e, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("held_start_idle", {ap_idle, rd_start, wr_start}, 4'b1000);
        end
        ap_start = 1'b0;

        // Done pulse while idle is spurious and persists until the next start
        @(negedge clk);
        wr_done = 1'b1;
        @(negedge clk);
        wr_done = 1'b0;
        @(negedge clk);
        chk("idle_spurious", status, 4'b0010);

        // Reset in the middle of a job aborts at once
        @(negedge clk);
        rdNumCLs = {32'd1, 32'd1};
        wrNumCLs = 32'd1;
        ap_start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_start", rd_start, 2'b11);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_abort_idle", {ap_idle, ap_done, rd_start, wr_start}, 5'b10000);
        chk("rst_abort_status", {status, run_cycles}, 0);
        chk("rst_abort_bytes", {rd_xfer_bytes, wr_xfer_bytes}, 0);
        ap_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Randomized jobs against the model
        for (int n = 0; n < 40; n++) begin
            job_t j;
            logic [31:0] c [3];
            for (int k = 0; k < 3; k++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 2)      c[k] = 32'd0;
                else if (r < 9) c[k] = $urandom_range(1, 1000);
                else            c[k] = $urandom;
            end
            j.r0  = c[0];
            j.r1  = c[1];
            j.w0  = c[2];
            j.d0  = $urandom_range(0, 18);
            j.d1  = $urandom_range(0, 18);
            j.dw  = $urandom_range(0, 18);
            j.dup = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 18) : 0;
            if (j.dup == j.d0) j.dup = 0;
            run_job(j, model(j), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule

`default_nettype wire
